// File: rtl/ldm_stm_sequencer_pkg.sv
// ldm_stm_sequencer_pkg: FSM encoding, {P,U} addressing-mode codes and block-transfer helpers.
package ldm_stm_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;
  localparam logic [1:0] MODE_DA = 2'b00;
  localparam logic [1:0] MODE_IA = 2'b01;
  localparam logic [1:0] MODE_DB = 2'b10;
  localparam logic [1:0] MODE_IB = 2'b11;
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    popcount16 = '0;
    for (int i = 0; i < 16; i++) popcount16 = popcount16 + {4'd0, v[i]};
  endfunction
  // Lowest address touched by the transfer; the sequence always walks upward from here.
  function automatic logic [31:0] start_addr(input logic [1:0] pu, input logic [31:0] base, input logic [4:0] n);
    logic [31:0] span;
    span = {25'd0, n, 2'b00};
    start_addr = base - span;
    case (pu)
      MODE_IA: start_addr = base;
      MODE_IB: start_addr = base + 32'd4;
      MODE_DA: start_addr = base - span + 32'd4;
      MODE_DB: start_addr = base - span;
      default: start_addr = base - span;
    endcase
  endfunction
endpackage

// File: rtl/ldm_stm_sequencer_lowest_set_bit.sv
// ldm_stm_sequencer_lowest_set_bit: 16-bit priority encoder giving the lowest set bit index.
module ldm_stm_sequencer_lowest_set_bit (
  input  logic [15:0] bits_i,
  output logic [3:0]  idx_o,
  output logic        valid_o
);
  always_comb begin
    idx_o = '0;
    for (int i = 15; i >= 0; i--) idx_o = bits_i[i] ? 4'(i) : idx_o;
  end
  assign valid_o = |bits_i;
endmodule

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: sequences LDM/STM block transfers one word per cycle on the data-memory port.
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  is_load_i,
  input  logic                  p_i,
  input  logic                  u_i,
  input  logic                  w_i,
  input  logic [3:0]            rn_i,
  input  logic [15:0]           reg_list_i,
  input  logic [31:0]           base_addr_i,
  input  logic [DATA_W-1:0]     store_data_i,
  output logic [3:0]            reg_idx_o,
  output logic                  reg_we_o,
  output logic [DATA_W-1:0]     reg_wd_o,
  output logic                  base_we_o,
  output logic [31:0]           base_wd_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [DATA_W-1:0]     mem_wd_o,
  input  logic [DATA_W-1:0]     mem_rd_i
);
  state_t      state_q, state_d;
  logic [15:0] list_q;
  logic [31:0] base_q, addr_q, span;
  logic [4:0]  n_q;
  logic        is_load_q, u_q, w_q, base_hit_q;
  logic [3:0]  idx;
  logic        valid, accept, step;

  ldm_stm_sequencer_lowest_set_bit u_lsb (
    .bits_i  (list_q),
    .idx_o   (idx),
    .valid_o (valid)
  );

  assign accept = state_q == IDLE && start_i;
  assign step   = state_q == XFER && valid;
  assign span   = {25'd0, n_q, 2'b00};

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      list_q     <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      n_q        <= '0;
      is_load_q  <= 1'b0;
      u_q        <= 1'b0;
      w_q        <= 1'b0;
      base_hit_q <= 1'b0;
    end else if (accept) begin
      list_q     <= reg_list_i;
      base_q     <= base_addr_i & ~32'd3;
      addr_q     <= start_addr({p_i, u_i}, base_addr_i & ~32'd3, popcount16(reg_list_i));
      n_q        <= popcount16(reg_list_i);
      is_load_q  <= is_load_i;
      u_q        <= u_i;
      w_q        <= w_i;
      base_hit_q <= is_load_i && reg_list_i[rn_i];
    end else if (step) begin
      list_q <= list_q & ~(16'd1 << idx);
      addr_q <= addr_q + 32'd4;
    end

  // XFER holds one extra cycle once the list is empty, giving Start-to-Done of n+2.
  always_comb
    state_d = state_q == IDLE ? (start_i ? XFER : IDLE) :
              state_q == XFER ? (valid ? XFER : (w_q && n_q != '0 ? WB : DONE)) :
              state_q == WB   ? DONE : IDLE;

  always_comb begin
    reg_idx_o  = step ? idx : '0;
    reg_we_o   = step && is_load_q;
    mem_we_o   = step && !is_load_q;
    reg_wd_o   = reg_we_o ? mem_rd_i : '0;
    mem_wd_o   = mem_we_o ? store_data_i : '0;
    mem_addr_o = step ? MEM_ADDR_W'(addr_q >> 2) : '0;
    base_we_o  = state_q == WB && !base_hit_q;
    base_wd_o  = state_q == WB ? (u_q ? base_q + span : base_q - span) : '0;
    busy_o     = state_q == XFER || state_q == WB;
    done_o     = state_q == DONE;
  end
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb_ldm_stm_sequencer: directed and randomized block transfers checked against a transfer-list model.
module tb_ldm_stm_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, is_load = 1'b0, p = 1'b0, u = 1'b0, w = 1'b0;
  logic [3:0]  rn = '0;
  logic [15:0] list = '0;
  logic [31:0] base = '0, store_data, reg_wd, base_wd, mem_wd, mem_rd, mem_addr;
  logic [3:0]  reg_idx;
  logic        reg_we, base_we, busy, done, mem_we;
  logic [31:0] sd_base = 32'hA0;
  logic [31:0] mem [256];
  logic [31:0] rf [16];
  int          n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  assign store_data = sd_base + {28'd0, reg_idx};
  assign mem_rd     = mem[mem_addr[7:0]];

  ldm_stm_sequencer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .is_load_i    (is_load),
    .p_i          (p),
    .u_i          (u),
    .w_i          (w),
    .rn_i         (rn),
    .reg_list_i   (list),
    .base_addr_i  (base),
    .store_data_i (store_data),
    .reg_idx_o    (reg_idx),
    .reg_we_o     (reg_we),
    .reg_wd_o     (reg_wd),
    .base_we_o    (base_we),
    .base_wd_o    (base_wd),
    .busy_o       (busy),
    .done_o       (done),
    .mem_addr_o   (mem_addr),
    .mem_we_o     (mem_we),
    .mem_wd_o     (mem_wd),
    .mem_rd_i     (mem_rd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_we"}, {29'd0, mem_we, reg_we, base_we}, 32'd0);
    check({tag, "_addr"}, mem_addr, 32'd0);
  endtask

  task automatic scramble();
    is_load = 1'($urandom); p = 1'($urandom); u = 1'($urandom); w = 1'($urandom);
    rn = 4'($urandom); list = 16'($urandom); base = $urandom;
  endtask

  // Expected sequence: registers ascending, addresses ascending from the mode's lowest word.
  task automatic run_op(input logic ld, input logic pp, input logic uu, input logic ww, input logic [3:0] rr,
                        input logic [15:0] ll, input logic [31:0] bb, input int pulse_at);
    int n, nc, k;
    int idxs[$];
    logic [31:0] b, a, span, ea;
    logic wb;
    n = $countones(ll);
    b = bb & ~32'd3;
    span = 32'(n) * 4;
    a = pp ? (uu ? b + 32'd4 : b - span) : (uu ? b : b - span + 32'd4);
    for (int i = 0; i < 16; i++) if (ll[i]) idxs.push_back(i);
    wb = ww && n != 0;
    nc = n + 2 + (wb ? 1 : 0);
    @(negedge clk);
    start = 1'b1; is_load = ld; p = pp; u = uu; w = ww; rn = rr; list = ll; base = bb;
    for (int c = 1; c <= nc; c++) begin
      @(negedge clk);
      scramble();
      start = (c == pulse_at);
      if (c <= n) begin
        k = c - 1;
        ea = (a + 32'(k) * 4) >> 2;
        check("xfer_busy", {31'd0, busy}, 32'd1);
        check("xfer_done", {31'd0, done}, 32'd0);
        check("reg_idx", {28'd0, reg_idx}, 32'(idxs[k]));
        check("mem_addr", mem_addr, ea);
        check("mem_we", {31'd0, mem_we}, {31'd0, !ld});
        check("reg_we", {31'd0, reg_we}, {31'd0, ld});
        check("xfer_base_we", {31'd0, base_we}, 32'd0);
        if (ld) begin
          check("reg_wd", reg_wd, mem[ea[7:0]]);
          rf[idxs[k]] = reg_wd;
        end else begin
          check("mem_wd", mem_wd, sd_base + 32'(idxs[k]));
          mem[ea[7:0]] = mem_wd;
        end
      end else if (c == n + 1) begin
        check("tail_busy", {31'd0, busy}, 32'd1);
        check("tail_done", {31'd0, done}, 32'd0);
        check_quiet("tail");
      end else if (wb && c == n + 2) begin
        check("wb_busy", {31'd0, busy}, 32'd1);
        check("wb_base_we", {31'd0, base_we}, {31'd0, !(ld && ll[rr])});
        check("wb_base_wd", base_wd, uu ? b + span : b - span);
        check({"wb", "_mem_reg_we"}, {30'd0, mem_we, reg_we}, 32'd0);
      end else begin
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd0);
        check_quiet("done");
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int i = 0; i < 16; i++) rf[i] = '0;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check_quiet("rst");
    @(negedge clk);
    rst = 1'b0;

    sd_base = 32'hA0;
    run_op(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h000B, 32'h40, 0);
    check("stmia_m16", mem[16], 32'hA0);
    check("stmia_m17", mem[17], 32'hA1);
    check("stmia_m18", mem[18], 32'hA3);

    mem[62] = 32'h11; mem[63] = 32'h22;
    run_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 16'h0024, 32'h100, 0);
    check("ldmdb_r2", rf[2], 32'h11);
    check("ldmdb_r5", rf[5], 32'h22);

    run_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 16'h0000, 32'h200, 0);

    mem[32] = 32'hCAFE0004;
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 16'h0010, 32'h80, 0);
    check("ldm_base_r4", rf[4], 32'hCAFE0004);

    run_op(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h00F0, 32'h300, 2);

    sd_base = 32'h5000;
    run_op(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0003, 32'h0, 0);
    check("wrap_hi", mem[255], 32'h5000);
    check("wrap_lo", mem[0], 32'h5001);

    // Cut a three-word STM after its first write.
    @(negedge clk);
    start = 1'b1; is_load = 1'b0; p = 1'b0; u = 1'b1; w = 1'b1; rn = 4'd0; list = 16'h0007; base = 32'h80;
    @(negedge clk);
    start = 1'b0;
    check("cut_w1_we", {31'd0, mem_we}, 32'd1);
    check("cut_w1_addr", mem_addr, 32'd32);
    @(negedge clk);
    check("cut_w2_we", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("cut_busy", {31'd0, busy}, 32'd0);
    check("cut_idx", {28'd0, reg_idx}, 32'd0);
    check_quiet("cut");
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0007, 32'h80, 0);

    for (int t = 0; t < 40; t++) begin
      logic [15:0] ll;
      sd_base = $urandom;
      ll = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
      run_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), ll,
             ($urandom_range(16, 200) << 2) | 32'($urandom_range(0, 3)),
             ($urandom_range(0, 2) == 0) ? $urandom_range(1, $countones(ll) + 1) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
